disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal when SCAN_DIV > BLANK_CYC.
REQ-002 SHALL have parameter BLANK_CYC, default 16, cycles per slot with all digits off; legal when BLANK_CYC >= 1.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: scanning runs while high.
REQ-007 SHALL have port val_valid, input, 1 bit: a new display value is offered.
REQ-008 SHALL have port val_data, input, 16 bits: four BCD nibbles; [3:0] is digit0 (rightmost).
REQ-009 SHALL have port val_ready, output, 1 bit: the pending register is empty.
REQ-010 SHALL have port lz_blank_en, input, 1 bit: leading-zero blanking on.
REQ-011 SHALL have port bcd, output, 4 bits: nibble sent to the shared BCD-to-7-segment decoder.
REQ-012 SHALL have port an, output, 4 bits: active-low digit enables; bit k drives digit k.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-014 SHALL have port err_nonbcd, output, 1 bit: one-cycle pulse when an accepted value holds a nibble above 9.

Function
REQ-015 FSM states SHALL be IDLE, SHOW and BLANK; all outputs SHALL be registered, Moore-style.
REQ-016 IDLE: an=4'hF, digit index 0, counters cleared; enable=1 SHALL go to SHOW for digit0 on the next cycle.
REQ-017 SHOW SHALL last SCAN_DIV-BLANK_CYC cycles with an[k]=0 for the current digit k, then go to BLANK.
REQ-018 BLANK SHALL last BLANK_CYC cycles with an=4'hF and bcd already holding the next digit's nibble; it then goes to SHOW for index k+1 mod 4.
REQ-019 One frame SHALL be exactly 4*SCAN_DIV cycles; the digit order SHALL be 0,1,2,3 with wrap to 0.
REQ-020 Handshake: a transfer SHALL occur when val_valid&val_ready; the value is stored in the pending register; val_ready SHALL be the inverse of pending-full.
REQ-021 The pending value SHALL move to the display register only at a frame boundary (last BLANK cycle of digit3) or on any cycle in IDLE; val_ready SHALL rise the following cycle.
REQ-022 If a transfer happens in the same cycle as a frame boundary while pending is empty, the value SHALL wait in pending until the next boundary.
REQ-023 val_valid with val_ready=0 SHALL be ignored; the producer holds it, and no data is lost or overwritten.
REQ-024 err_nonbcd SHALL pulse in the cycle after a transfer with any nibble >9; that nibble SHALL still be passed through unchanged.
REQ-025 With lz_blank_en=1, digit k (k=3..1) SHALL keep an[k]=1 during its SHOW if it and all higher display nibbles are zero; digit0 is never blanked.
REQ-026 frame_done SHALL pulse in the cycle after the frame-boundary cycle; it SHALL not pulse in IDLE.
REQ-027 If enable goes low mid-frame, the block SHALL enter IDLE on the next cycle with an=4'hF; the pending and display registers SHALL be kept.

Reset
REQ-028 On rst=1 the block SHALL immediately go to IDLE with an=4'hF, bcd=0, val_ready=1, frame_done=0, err_nonbcd=0, display=16'h0000, pending empty.
REQ-029 Reset asserted mid-frame or mid-handshake SHALL discard the pending value; scanning SHALL restart from digit0 once rst=0 and enable=1.

Structure
REQ-030 Package disp_pkg SHALL hold the state enum, N_DIGITS=4 and AN_OFF=4'hF.
REQ-031 The slot/blank cycle counting SHALL live in one sub-module, scan_timer; the decoder SHALL stay outside this block.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-032 Reset, enable=1, load 16'h1234 -> an sequence 1110 (6 cycles), 1111 (2), 1101 (6)...; bcd 4,3,2,1; frame_done every 32 cycles.
REQ-033 Load 16'h0042 with lz_blank_en=1 -> an[3] and an[2] held high for their slots; digits 1 and 0 show 4 and 2.
REQ-034 Load 16'h0000 with lz_blank_en=1 -> only digit0 shows 0.
REQ-035 Mid-frame load of 16'h5678, then 16'h9999 offered -> val_ready=0 until the boundary; 5678 appears from the next frame; 9999 is accepted only after ready rises.
REQ-036 Load 16'h00A0 -> err_nonbcd pulses once; bcd=4'hA during digit1.
REQ-037 Drop enable, and separately assert rst, at cycle 13 of a frame -> an=4'hF next cycle; restart begins at digit0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit multiplexed BCD display scanner.
package disp_pkg;

   typedef enum logic [1:0] {StIdle, StShow, StBlank} scan_state_e;

   localparam int unsigned N_DIGITS = 4;
   localparam logic [3:0]  AN_OFF   = 4'hF;

   function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] k);
      return d[4*k +: 4];
   endfunction

   function automatic logic has_nonbcd(input logic [15:0] d);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (d[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Digit k is suppressed when it and every more-significant nibble are zero.
   function automatic logic [3:0] an_pattern(input logic [15:0] d, input logic [1:0] k,
                                             input logic lz);
      logic blank;
      case (k)
         2'd3:    blank = (d[15:12] == 4'h0);
         2'd2:    blank = (d[15:8] == 8'h00);
         2'd1:    blank = (d[15:4] == 12'h000);
         default: blank = 1'b0;
      endcase
      return (lz && blank) ? AN_OFF : ~(4'b0001 << k);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Per-slot cycle counter: flags the last lit cycle and the last cycle of each digit slot.
module scan_timer #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic show_end_o,
   output logic slot_end_o
);

   localparam int unsigned     CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] ShowLast = CntW'(SCAN_DIV - BLANK_CYC - 1);
   localparam logic [CntW-1:0] SlotLast = CntW'(SCAN_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!run_i || cnt_q == SlotLast) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign show_end_o = run_i && (cnt_q == ShowLast);
   assign slot_end_o = run_i && (cnt_q == SlotLast);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner with a frame-synchronised value handshake.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        val_valid,
   input  logic [15:0] val_data,
   output logic        val_ready,
   input  logic        lz_blank_en,
   output logic [3:0]  bcd,
   output logic [3:0]  an,
   output logic        frame_done,
   output logic        err_nonbcd
);

   scan_state_e state_q;
   logic [1:0]  idx_q, idx_nxt;
   logic [15:0] pend_q, disp_q, disp_d;
   logic        ready_q, ready_d, err_q, fd_q;
   logic [3:0]  an_q, bcd_q;
   logic        run, show_end, slot_end, frame_end, xfer, load_disp;

   assign run = (state_q != StIdle) && enable;

   scan_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_scan_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .run_i      (run),
      .show_end_o (show_end),
      .slot_end_o (slot_end)
   );

   assign idx_nxt   = idx_q + 2'd1;
   assign frame_end = (state_q == StBlank) && slot_end && (idx_q == 2'(N_DIGITS - 1));
   assign xfer      = val_valid && ready_q;
   // A new value only replaces the display between whole frames, or while stopped.
   assign load_disp = !ready_q && (frame_end || state_q == StIdle);

   always_comb begin
      disp_d  = load_disp ? pend_q : disp_q;
      ready_d = ready_q;
      if (load_disp) begin
         ready_d = 1'b1;
      end else if (xfer) begin
         ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q  <= 16'h0000;
         disp_q  <= 16'h0000;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         disp_q  <= disp_d;
         ready_q <= ready_d;
         err_q   <= xfer && has_nonbcd(val_data);
         if (xfer) pend_q <= val_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         an_q    <= AN_OFF;
         bcd_q   <= 4'h0;
         fd_q    <= 1'b0;
      end else begin
         fd_q <= frame_end;
         case (state_q)
            StIdle: begin
               if (enable) begin
                  state_q <= StShow;
                  idx_q   <= 2'd0;
                  an_q    <= an_pattern(disp_d, 2'd0, lz_blank_en);
                  bcd_q   <= nibble(disp_d, 2'd0);
               end
            end
            StShow: begin
               if (!enable) begin
                  state_q <= StIdle;
                  idx_q   <= 2'd0;
                  an_q    <= AN_OFF;
               end else if (show_end) begin
                  state_q <= StBlank;
                  an_q    <= AN_OFF;
                  bcd_q   <= nibble(disp_d, idx_nxt);
               end
            end
            StBlank: begin
               if (!enable) begin
                  state_q <= StIdle;
                  idx_q   <= 2'd0;
                  an_q    <= AN_OFF;
               end else if (slot_end) begin
                  state_q <= StShow;
                  idx_q   <= idx_nxt;
                  an_q    <= an_pattern(disp_d, idx_nxt, lz_blank_en);
                  bcd_q   <= nibble(disp_d, idx_nxt);
               end
            end
            default: begin
               state_q <= StIdle;
               idx_q   <= 2'd0;
               an_q    <= AN_OFF;
            end
         endcase
      end
   end

   assign val_ready  = ready_q;
   assign an         = an_q;
   assign bcd        = bcd_q;
   assign frame_done = fd_q;
   assign err_nonbcd = err_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with a short scan period (8 cycles per slot, 2 blank).
module tb_disp_scan_ctrl;

   localparam int SD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        rst, enable, val_valid, lz_blank_en;
   logic [15:0] val_data;
   logic        val_ready, frame_done, err_nonbcd;
   logic [3:0]  bcd, an;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       bcd_x;
      logic       fd;
      logic       rdy;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   disp_scan_ctrl #(
      .SCAN_DIV  (SD),
      .BLANK_CYC (BC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .val_valid   (val_valid),
      .val_data    (val_data),
      .val_ready   (val_ready),
      .lz_blank_en (lz_blank_en),
      .bcd         (bcd),
      .an          (an),
      .frame_done  (frame_done),
      .err_nonbcd  (err_nonbcd)
   );

   // Expected outputs t cycles after the first lit cycle of a frame, value d on display.
   function automatic exp_t model_at(input logic [15:0] d, input logic lz, input int t);
      exp_t r;
      int   pos;
      int   k;
      int   kn;
      pos     = t % SD;
      k       = (t / SD) % 4;
      kn      = (k + 1) % 4;
      r.bcd_x = 1'b0;
      r.rdy   = 1'b1;
      r.err   = 1'b0;
      r.fd    = (t > 0) && (t % FRAME == 0);
      if (pos < SD - BC) begin
         r.bcd = d[4*k +: 4];
         r.an  = (lz && k > 0 && (d >> (4 * k)) == 16'h0000) ? 4'hF : ~(4'b0001 << k);
      end else begin
         r.bcd = d[4*kn +: 4];
         r.an  = 4'hF;
      end
      return r;
   endfunction

   function automatic exp_t reset_exp();
      return '{an: 4'hF, bcd: 4'h0, bcd_x: 1'b0, fd: 1'b0, rdy: 1'b1, err: 1'b0};
   endfunction

   // Reset, load v while stopped, then enable; the next negedge is frame cycle 0.
   task automatic start_scan(input logic [15:0] v, input logic lz);
      @(negedge clk);
      rst = 1'b1; enable = 1'b0; val_valid = 1'b0; lz_blank_en = lz;
      @(negedge clk);
      rst = 1'b0; val_valid = 1'b1; val_data = v;
      @(negedge clk);
      val_valid = 1'b0;
      @(negedge clk);
      enable = 1'b1;
   endtask

   task automatic test_reset();
      for (int p = 0; p < 3; p++) begin
         if (p == 0) begin
            repeat (2) @(negedge clk);
            sb.push_back(reset_exp());
         end else if (p == 1) begin
            rst = 1'b0; enable = 1'b1;
            sb.push_back(model_at(16'h0000, 1'b0, 0));
            @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
            #2 rst = 1'b1;
            sb.push_back(reset_exp());
            #1;
         end
         e = sb.pop_front();
         n_vec++;
         if (an !== e.an || bcd !== e.bcd || frame_done !== e.fd || val_ready !== e.rdy ||
             err_nonbcd !== e.err) begin
            n_err++;
            $display("FAIL reset p=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                     p, an, bcd, frame_done, val_ready, err_nonbcd, e.an, e.bcd, e.fd, e.rdy, e.err);
         end
      end
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
   endtask

   task automatic test_scan_1234();
      start_scan(16'h1234, 1'b0);
      for (int t = 0; t < 70; t++) sb.push_back(model_at(16'h1234, 1'b0, t));
      for (int t = 0; t < 70; t++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_vec++;
         if (an !== e.an || bcd !== e.bcd || frame_done !== e.fd || val_ready !== e.rdy ||
             err_nonbcd !== e.err) begin
            n_err++;
            $display("FAIL scan_1234 t=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                     t, an, bcd, frame_done, val_ready, err_nonbcd, e.an, e.bcd, e.fd, e.rdy, e.err);
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [15:0] vals [2];
      vals[0] = 16'h0042;
      vals[1] = 16'h0000;
      for (int v = 0; v < 2; v++) begin
         start_scan(vals[v], 1'b1);
         for (int t = 0; t < FRAME; t++) sb.push_back(model_at(vals[v], 1'b1, t));
         for (int t = 0; t < FRAME; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (an !== e.an || bcd !== e.bcd || frame_done !== e.fd || val_ready !== e.rdy ||
                err_nonbcd !== e.err) begin
               n_err++;
               $display("FAIL lz_blank v=%h t=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                        vals[v], t, an, bcd, frame_done, val_ready, err_nonbcd,
                        e.an, e.bcd, e.fd, e.rdy, e.err);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t x;
      start_scan(16'h1234, 1'b0);
      for (int t = 0; t < 100; t++) begin
         x     = model_at((t < 64) ? 16'h1234 : (t < 96) ? 16'h5678 : 16'h9999, 1'b0, t);
         x.rdy = (t <= 40) || (t == 64) || (t >= 96);
         sb.push_back(x);
      end
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_vec++;
         if (an !== e.an || bcd !== e.bcd || frame_done !== e.fd || val_ready !== e.rdy ||
             err_nonbcd !== e.err) begin
            n_err++;
            $display("FAIL back_to_back t=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                     t, an, bcd, frame_done, val_ready, err_nonbcd, e.an, e.bcd, e.fd, e.rdy, e.err);
         end
         if (t == 40) begin
            val_valid = 1'b1; val_data = 16'h5678;
         end
         if (t == 41) val_data = 16'h9999;
         if (t == 65) val_valid = 1'b0;
      end
   endtask

   // Non-BCD value offered exactly on a frame-boundary cycle with pending empty.
   task automatic test_nonbcd_boundary();
      exp_t x;
      start_scan(16'h0000, 1'b0);
      for (int t = 0; t < 80; t++) begin
         x     = model_at((t < 64) ? 16'h0000 : 16'h00A0, 1'b0, t);
         x.rdy = (t < 32) || (t >= 64);
         x.err = (t == 32);
         sb.push_back(x);
      end
      for (int t = 0; t < 80; t++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_vec++;
         if (an !== e.an || bcd !== e.bcd || frame_done !== e.fd || val_ready !== e.rdy ||
             err_nonbcd !== e.err) begin
            n_err++;
            $display("FAIL nonbcd t=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                     t, an, bcd, frame_done, val_ready, err_nonbcd, e.an, e.bcd, e.fd, e.rdy, e.err);
         end
         if (t == 31) begin
            val_valid = 1'b1; val_data = 16'h00A0;
         end
         if (t == 32) val_valid = 1'b0;
      end
   endtask

   task automatic test_enable_drop();
      exp_t x;
      start_scan(16'h1234, 1'b0);
      for (int t = 0; t < 49; t++) begin
         if (t <= 13) begin
            x = model_at(16'h1234, 1'b0, t);
         end else if (t == 14) begin
            x       = reset_exp();
            x.bcd_x = 1'b1;
         end else begin
            x = model_at(16'h1234, 1'b0, t - 15);
         end
         sb.push_back(x);
      end
      for (int t = 0; t < 49; t++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_vec++;
         if (an !== e.an || (!e.bcd_x && bcd !== e.bcd) || frame_done !== e.fd ||
             val_ready !== e.rdy || err_nonbcd !== e.err) begin
            n_err++;
            $display("FAIL enable_drop t=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                     t, an, bcd, frame_done, val_ready, err_nonbcd, e.an, e.bcd, e.fd, e.rdy, e.err);
         end
         if (t == 13) enable = 1'b0;
         if (t == 14) enable = 1'b1;
      end
   endtask

   // Reset mid-frame with a value parked in pending: it must be gone afterwards.
   task automatic test_reset_mid();
      exp_t x;
      start_scan(16'h1234, 1'b0);
      for (int t = 0; t < 49; t++) begin
         if (t <= 13) begin
            x     = model_at(16'h1234, 1'b0, t);
            x.rdy = (t <= 10);
         end else if (t == 14) begin
            x = reset_exp();
         end else begin
            x = model_at(16'h0000, 1'b0, t - 15);
         end
         sb.push_back(x);
      end
      for (int t = 0; t < 49; t++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_vec++;
         if (an !== e.an || bcd !== e.bcd || frame_done !== e.fd || val_ready !== e.rdy ||
             err_nonbcd !== e.err) begin
            n_err++;
            $display("FAIL reset_mid t=%0d got an=%b bcd=%h fd=%b rdy=%b err=%b want an=%b bcd=%h fd=%b rdy=%b err=%b",
                     t, an, bcd, frame_done, val_ready, err_nonbcd, e.an, e.bcd, e.fd, e.rdy, e.err);
         end
         if (t == 10) begin
            val_valid = 1'b1; val_data = 16'h5678;
         end
         if (t == 13) begin
            rst = 1'b1; val_valid = 1'b0;
         end
         if (t == 14) rst = 1'b0;
      end
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      val_valid   = 1'b0;
      val_data    = 16'h0000;
      lz_blank_en = 1'b0;
      test_reset();
      test_scan_1234();
      test_lz_blank();
      test_back_to_back();
      test_nonbcd_boundary();
      test_enable_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
